// File: rtl/pe_sequencer_if.sv
// Control/status bundle between the host, pe_sequencer and the PE convolution datapath.
// The slave modport is the sequencer's view; master is the host/datapath side.
interface pe_sequencer_if #(
  parameter int unsigned FILT_ADDR_LEN  = 5,
  parameter int unsigned PSUM_CNT_LEN   = 4,
  parameter int unsigned STRIDE_CNT_LEN = 8
);
  logic                      start;
  logic                      abort;
  logic [1:0]                cfg_mode;
  logic                      cfg_psum_mode;
  logic [FILT_ADDR_LEN-1:0]  cfg_filt_len;
  logic [PSUM_CNT_LEN-1:0]   cfg_psum_total;
  logic                      filt_buf_read;
  logic                      psum_done;
  logic                      full_done;
  logic                      stride_count_flag;
  logic                      regs_clr;
  logic                      filter_read_start;
  logic                      IF_read_start;
  logic                      start_rd_gen;
  logic [1:0]                mode;
  logic                      psum_mode;
  logic                      busy;
  logic                      done;
  logic [PSUM_CNT_LEN-1:0]   psum_cnt;
  logic [STRIDE_CNT_LEN-1:0] stride_cnt;

  modport master (
    output start, abort, cfg_mode, cfg_psum_mode, cfg_filt_len, cfg_psum_total,
    output filt_buf_read, psum_done, full_done, stride_count_flag,
    input  regs_clr, filter_read_start, IF_read_start, start_rd_gen,
    input  mode, psum_mode, busy, done, psum_cnt, stride_cnt
  );

  modport slave (
    input  start, abort, cfg_mode, cfg_psum_mode, cfg_filt_len, cfg_psum_total,
    input  filt_buf_read, psum_done, full_done, stride_count_flag,
    output regs_clr, filter_read_start, IF_read_start, start_rd_gen,
    output mode, psum_mode, busy, done, psum_cnt, stride_cnt
  );
endinterface

// File: rtl/pe_sequencer.sv
// Job-level control FSM for the PE convolution datapath: sequences clear, filter load and
// read start strobes, then counts partial sums until end of job. All outputs are registered.
module pe_sequencer #(
  parameter int unsigned FILT_ADDR_LEN  = 5,
  parameter int unsigned PSUM_CNT_LEN   = 4,
  parameter int unsigned STRIDE_CNT_LEN = 8,
  parameter int unsigned DRAIN_CYC      = 2
) (
  input logic            clk,
  input logic            rst,
  pe_sequencer_if.slave  bus
);

  localparam int unsigned DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DRAIN_W-1:0]        DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);
  localparam logic [STRIDE_CNT_LEN-1:0] STRIDE_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_FILT, S_FWAIT, S_GO, S_RUN, S_DRAIN, S_DONE
  } state_e;

  state_e                    state_q, state_d;
  logic [1:0]                mode_q, mode_d;
  logic                      psum_mode_q, psum_mode_d;
  logic [FILT_ADDR_LEN-1:0]  filt_len_q, filt_len_d;
  logic [PSUM_CNT_LEN-1:0]   psum_total_q, psum_total_d;
  logic [FILT_ADDR_LEN-1:0]  filt_cnt_q, filt_cnt_d;
  logic [PSUM_CNT_LEN-1:0]   psum_cnt_q, psum_cnt_d;
  logic [STRIDE_CNT_LEN-1:0] stride_cnt_q, stride_cnt_d;
  logic [DRAIN_W-1:0]        drain_cnt_q, drain_cnt_d;
  logic                      regs_clr_q, regs_clr_d;
  logic                      filt_start_q, filt_start_d;
  logic                      go_q, go_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  // Next state, counters and strobes; strobes decode the next state so they are Moore outputs.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    psum_mode_d  = psum_mode_q;
    filt_len_d   = filt_len_q;
    psum_total_d = psum_total_q;
    filt_cnt_d   = filt_cnt_q;
    psum_cnt_d   = psum_cnt_q;
    stride_cnt_d = stride_cnt_q;
    drain_cnt_d  = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d      = S_CLR;
          mode_d       = bus.cfg_mode;
          psum_mode_d  = bus.cfg_psum_mode;
          filt_len_d   = bus.cfg_filt_len;
          psum_total_d = bus.cfg_psum_total;
        end
      end
      S_CLR:   state_d = psum_mode_q ? S_GO : S_FILT;
      S_FILT:  state_d = S_FWAIT;
      S_FWAIT: begin
        filt_cnt_d = filt_cnt_q + FILT_ADDR_LEN'(bus.filt_buf_read);
        if (filt_cnt_d == filt_len_q) begin
          state_d = S_GO;
        end
      end
      S_GO:    state_d = S_RUN;
      S_RUN: begin
        if (bus.psum_done) begin
          psum_cnt_d = psum_cnt_q + PSUM_CNT_LEN'(1);
        end
        if (bus.stride_count_flag && (stride_cnt_q != STRIDE_MAX)) begin
          stride_cnt_d = stride_cnt_q + STRIDE_CNT_LEN'(1);
        end
        // A zero psum total means the job ends only on full_done.
        if (bus.full_done ||
            (bus.psum_done && (psum_total_q != '0) && (psum_cnt_d == psum_total_q))) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus.psum_done) begin
          psum_cnt_d = psum_cnt_q + PSUM_CNT_LEN'(1);
        end
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = S_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything and freezes the counters.
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      filt_cnt_d   = filt_cnt_q;
      psum_cnt_d   = psum_cnt_q;
      stride_cnt_d = stride_cnt_q;
      drain_cnt_d  = '0;
    end

    if (state_d == S_CLR) begin
      filt_cnt_d   = '0;
      psum_cnt_d   = '0;
      stride_cnt_d = '0;
    end

    regs_clr_d   = (state_d == S_CLR);
    filt_start_d = (state_d == S_FILT);
    go_d         = (state_d == S_GO);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      mode_q       <= '0;
      psum_mode_q  <= 1'b0;
      filt_len_q   <= '0;
      psum_total_q <= '0;
      filt_cnt_q   <= '0;
      psum_cnt_q   <= '0;
      stride_cnt_q <= '0;
      drain_cnt_q  <= '0;
      regs_clr_q   <= 1'b0;
      filt_start_q <= 1'b0;
      go_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      psum_mode_q  <= psum_mode_d;
      filt_len_q   <= filt_len_d;
      psum_total_q <= psum_total_d;
      filt_cnt_q   <= filt_cnt_d;
      psum_cnt_q   <= psum_cnt_d;
      stride_cnt_q <= stride_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      regs_clr_q   <= regs_clr_d;
      filt_start_q <= filt_start_d;
      go_q         <= go_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.regs_clr          = regs_clr_q;
  assign bus.filter_read_start = filt_start_q;
  assign bus.IF_read_start     = go_q;
  assign bus.start_rd_gen      = go_q;
  assign bus.mode              = mode_q;
  assign bus.psum_mode         = psum_mode_q;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.psum_cnt          = psum_cnt_q;
  assign bus.stride_cnt        = stride_cnt_q;

endmodule

// File: tb/tb_pe_sequencer.sv
// Randomised job-level bench for pe_sequencer: predicts strobe cycles and final counts
// from the job timing rules and the pulses it drives.
module tb_pe_sequencer;
  localparam int unsigned FL = 5;
  localparam int unsigned PL = 4;
  localparam int unsigned SL = 8;
  localparam int unsigned DC = 2;

  logic clk;
  logic rst;

  pe_sequencer_if #(.FILT_ADDR_LEN(FL), .PSUM_CNT_LEN(PL), .STRIDE_CNT_LEN(SL)) bus ();

  pe_sequencer #(
    .FILT_ADDR_LEN(FL), .PSUM_CNT_LEN(PL), .STRIDE_CNT_LEN(SL), .DRAIN_CYC(DC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Per-job event log filled by observe()
  int n_clr, n_filt, n_go, n_done, n_split, n_consec, n_mode_bad, n_busy_low;
  int clr_at, filt_at, go_at, done_at;
  logic [PL-1:0] done_psum;
  logic [SL-1:0] done_stride;
  logic [3:0]    prev_s;
  logic [1:0]    mode_exp;
  logic          pm_exp;
  bit            in_job;
  int            str_n;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_log();
    n_clr = 0; n_filt = 0; n_go = 0; n_done = 0; n_split = 0; n_consec = 0;
    n_mode_bad = 0; n_busy_low = 0;
    clr_at = -1; filt_at = -1; go_at = -1; done_at = -1;
    done_psum = '0; done_stride = '0; prev_s = '0; in_job = 1'b0; str_n = 0;
  endtask

  task automatic observe();
    logic [3:0] s;
    s = {bus.regs_clr, bus.filter_read_start, bus.IF_read_start, bus.done};
    if (bus.regs_clr)          begin n_clr++;  clr_at  = cyc; end
    if (bus.filter_read_start) begin n_filt++; filt_at = cyc; end
    if (bus.IF_read_start)     begin n_go++;   go_at   = cyc; end
    if (bus.IF_read_start !== bus.start_rd_gen) n_split++;
    if (bus.done) begin
      n_done++; done_at = cyc; done_psum = bus.psum_cnt; done_stride = bus.stride_cnt;
    end
    if ((s & prev_s) != 4'b0) n_consec++;
    prev_s = s;
    if (bus.busy && ({bus.mode, bus.psum_mode} !== {mode_exp, pm_exp})) n_mode_bad++;
    if (in_job && !bus.busy) n_busy_low++;
  endtask

  task automatic drive_stride(input int pct);
    bus.stride_count_flag = (int'($urandom_range(99)) < pct);
    if (bus.stride_count_flag) str_n++;
  endtask

  task automatic scramble_cfg();
    bus.cfg_mode       = 2'($urandom);
    bus.cfg_psum_mode  = 1'($urandom);
    bus.cfg_filt_len   = FL'($urandom);
    bus.cfg_psum_total = PL'($urandom);
  endtask

  function automatic logic [20:0] all_outs();
    return {bus.regs_clr, bus.filter_read_start, bus.IF_read_start, bus.start_rd_gen,
            bus.mode, bus.psum_mode, bus.busy, bus.done, bus.psum_cnt, bus.stride_cnt};
  endfunction

  // Runs one complete job from an IDLE cycle and checks it against the job timing model.
  task automatic run_job(input string tag, input logic [1:0] m, input bit pm,
                         input logic [FL-1:0] fl, input logic [PL-1:0] tot, input int npsum,
                         input int max_gap, input int tail, input int pct,
                         input bit drain_psum, input bit hold_start);
    int c0, exp_go, k, exp_done, psum_n, np, gap;
    int exp_stride;
    reset_log();
    mode_exp = m; pm_exp = pm;
    bus.cfg_mode = m; bus.cfg_psum_mode = pm; bus.cfg_filt_len = fl; bus.cfg_psum_total = tot;
    bus.start = 1'b1;
    c0 = cyc;
    in_job = 1'b1;
    tick(); observe();
    if (!hold_start) bus.start = 1'b0;
    scramble_cfg();
    if (pm) begin
      exp_go = c0 + 2;
    end else begin
      tick(); observe();
      exp_go = c0 + 4;
      for (int i = 0; i < int'(fl); i++) begin
        gap = int'($urandom_range(max_gap));
        repeat (gap) begin tick(); observe(); bus.filt_buf_read = 1'b0; end
        tick(); observe(); bus.filt_buf_read = 1'b1; exp_go = cyc + 1;
      end
    end
    while (cyc < exp_go) begin tick(); observe(); bus.filt_buf_read = 1'b0; end

    np = (tot != '0) ? int'(tot) : npsum;
    psum_n = 0;
    k = cyc;
    for (int i = 0; i < np; i++) begin
      gap = int'($urandom_range(max_gap));
      repeat (gap) begin tick(); observe(); bus.psum_done = 1'b0; drive_stride(pct); end
      tick(); observe(); bus.psum_done = 1'b1; psum_n++; drive_stride(pct); k = cyc;
    end
    if (tot == '0) begin
      if (np == 0 || tail > 0 || $urandom_range(1) == 0) begin
        repeat (tail) begin tick(); observe(); bus.psum_done = 1'b0; drive_stride(pct); end
        tick(); observe(); bus.psum_done = 1'b0; drive_stride(pct);
      end
      bus.full_done = 1'b1;
      k = cyc;
    end
    exp_done = k + int'(DC) + 1;

    tick(); observe();
    bus.psum_done = 1'b0; bus.full_done = 1'b0; bus.stride_count_flag = 1'b0;
    if (drain_psum) begin bus.psum_done = 1'b1; psum_n++; end
    while (cyc < exp_done) begin tick(); observe(); bus.psum_done = 1'b0; end
    in_job = 1'b0;
    tick(); observe();

    exp_stride = (str_n > 255) ? 255 : str_n;
    n_cmp++; if (n_clr !== 1 || clr_at !== c0 + 1) begin n_bad++;
      $display("FAIL %s regs_clr: count %0d at %0d, required 1 at %0d", tag, n_clr, clr_at, c0 + 1); end
    n_cmp++; if (n_filt !== (pm ? 0 : 1)) begin n_bad++;
      $display("FAIL %s filter_read_start count: got %0d required %0d", tag, n_filt, pm ? 0 : 1); end
    if (!pm) begin
      n_cmp++; if (filt_at !== c0 + 2) begin n_bad++;
        $display("FAIL %s filter_read_start cycle: got %0d required %0d", tag, filt_at, c0 + 2); end
    end
    n_cmp++; if (n_go !== 1 || go_at !== exp_go) begin n_bad++;
      $display("FAIL %s GO: count %0d at %0d, required 1 at %0d", tag, n_go, go_at, exp_go); end
    n_cmp++; if (n_split !== 0) begin n_bad++;
      $display("FAIL %s GO pair split: %0d cycles, required 0", tag, n_split); end
    n_cmp++; if (n_done !== 1 || done_at !== exp_done) begin n_bad++;
      $display("FAIL %s done: count %0d at %0d, required 1 at %0d", tag, n_done, done_at, exp_done); end
    n_cmp++; if (done_psum !== PL'(psum_n)) begin n_bad++;
      $display("FAIL %s psum_cnt at done: got %0d required %0d", tag, done_psum, PL'(psum_n)); end
    n_cmp++; if (done_stride !== SL'(exp_stride)) begin n_bad++;
      $display("FAIL %s stride_cnt at done: got %0d required %0d", tag, done_stride, exp_stride); end
    n_cmp++; if (n_mode_bad !== 0) begin n_bad++;
      $display("FAIL %s mode/psum_mode drift: %0d cycles, required 0", tag, n_mode_bad); end
    n_cmp++; if (n_consec !== 0) begin n_bad++;
      $display("FAIL %s consecutive strobe: %0d, required 0", tag, n_consec); end
    n_cmp++; if (n_busy_low !== 0) begin n_bad++;
      $display("FAIL %s busy low in job: %0d cycles, required 0", tag, n_busy_low); end
    n_cmp++; if (bus.busy !== 1'b0 || bus.psum_cnt !== PL'(psum_n)) begin n_bad++;
      $display("FAIL %s after done: busy %0b psum_cnt %0d, required 0 and %0d",
               tag, bus.busy, bus.psum_cnt, PL'(psum_n)); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 0; bus.abort = 0; bus.cfg_mode = 0; bus.cfg_psum_mode = 0;
    bus.cfg_filt_len = 0; bus.cfg_psum_total = 0; bus.filt_buf_read = 0;
    bus.psum_done = 0; bus.full_done = 0; bus.stride_count_flag = 0;
    reset_log();
    #12;
    n_cmp++; if (all_outs() !== 21'd0) begin n_bad++;
      $display("FAIL reset outputs: got %h required 0", all_outs()); end
    @(negedge clk); rst = 1'b1;
    repeat (3) begin tick(); observe(); end
    n_cmp++; if (bus.busy !== 1'b0 || n_clr !== 0) begin n_bad++;
      $display("FAIL idle after reset: busy %0b clr %0d, required 0 0", bus.busy, n_clr); end
  endtask

  task automatic test_reset_mid_run();
    reset_log();
    mode_exp = 2'b11; pm_exp = 1'b1;
    bus.cfg_mode = 2'b11; bus.cfg_psum_mode = 1'b1; bus.cfg_psum_total = '0;
    bus.start = 1'b1;
    tick(); observe(); bus.start = 1'b0;
    tick(); observe();
    tick(); observe(); bus.psum_done = 1'b1; bus.stride_count_flag = 1'b1;
    tick(); observe(); bus.psum_done = 1'b0; bus.stride_count_flag = 1'b0;
    n_cmp++; if (bus.busy !== 1'b1 || bus.psum_cnt !== 4'd1 || bus.stride_cnt !== 8'd1) begin n_bad++;
      $display("FAIL pre-reset run: busy %0b psum %0d stride %0d, required 1 1 1",
               bus.busy, bus.psum_cnt, bus.stride_cnt); end
    #3 rst = 1'b0;
    #1;
    n_cmp++; if (all_outs() !== 21'd0) begin n_bad++;
      $display("FAIL async reset mid-run: got %h required 0", all_outs()); end
    #1 rst = 1'b1;
    reset_log();
    repeat (4) begin tick(); observe(); end
    n_cmp++; if (bus.busy !== 1'b0 || n_clr !== 0 || bus.psum_cnt !== '0) begin n_bad++;
      $display("FAIL idle after mid-run reset: busy %0b clr %0d psum %0d, required 0 0 0",
               bus.busy, n_clr, bus.psum_cnt); end
  endtask

  task automatic test_filter_job();
    run_job("filt", 2'b01, 1'b0, 5'd3, 4'd4, 0, 2, 0, 30, 1'b0, 1'b0);
  endtask

  task automatic test_psum_mode();
    run_job("pmode", 2'b10, 1'b1, 5'd7, 4'd5, 0, 1, 0, 50, 1'b1, 1'b0);
  endtask

  task automatic test_full_done();
    run_job("full", 2'b11, 1'b0, 5'd0, 4'd0, 7, 2, 3, 40, 1'b0, 1'b0);
    run_job("wrap", 2'b00, 1'b1, 5'd1, 4'd0, 17, 0, 0, 20, 1'b1, 1'b0);
    run_job("tot15", 2'b01, 1'b1, 5'd0, 4'd15, 0, 0, 0, 10, 1'b1, 1'b0);
    run_job("sat", 2'b10, 1'b1, 5'd0, 4'd0, 0, 0, 300, 100, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    reset_log();
    mode_exp = 2'b01; pm_exp = 1'b0;
    bus.cfg_mode = 2'b01; bus.cfg_psum_mode = 1'b0; bus.cfg_filt_len = 5'd3;
    bus.cfg_psum_total = 4'd2; bus.start = 1'b1;
    tick(); observe(); bus.start = 1'b0;
    tick(); observe();
    tick(); observe(); bus.filt_buf_read = 1'b1;
    tick(); observe(); bus.filt_buf_read = 1'b0; bus.abort = 1'b1;
    tick(); observe(); bus.abort = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0 || bus.IF_read_start !== 1'b0) begin n_bad++;
      $display("FAIL abort fwait: busy %0b go %0b, required 0 0", bus.busy, bus.IF_read_start); end
    repeat (6) begin tick(); observe(); end
    n_cmp++; if (n_go !== 0 || n_done !== 0 || bus.busy !== 1'b0) begin n_bad++;
      $display("FAIL abort fwait aftermath: go %0d done %0d busy %0b, required 0 0 0",
               n_go, n_done, bus.busy); end

    reset_log();
    mode_exp = 2'b10; pm_exp = 1'b1;
    bus.cfg_mode = 2'b10; bus.cfg_psum_mode = 1'b1; bus.cfg_psum_total = 4'd0; bus.start = 1'b1;
    tick(); observe(); bus.start = 1'b0;
    tick(); observe();
    tick(); observe(); bus.psum_done = 1'b1;
    tick(); observe();
    tick(); observe(); bus.abort = 1'b1;
    tick(); observe(); bus.abort = 1'b0; bus.psum_done = 1'b0;
    repeat (4) begin tick(); observe(); end
    n_cmp++; if (bus.busy !== 1'b0 || n_done !== 0 || bus.psum_cnt !== 4'd2) begin n_bad++;
      $display("FAIL abort run: busy %0b done %0d psum %0d, required 0 0 2",
               bus.busy, n_done, bus.psum_cnt); end
  endtask

  task automatic test_back_to_back();
    int d1;
    run_job("b2b1", 2'b01, 1'b0, 5'd2, 4'd3, 0, 1, 0, 30, 1'b0, 1'b1);
    d1 = done_at;
    run_job("b2b2", 2'b10, 1'b1, 5'd0, 4'd2, 0, 1, 0, 30, 1'b0, 1'b0);
    n_cmp++; if (clr_at !== d1 + 2) begin n_bad++;
      $display("FAIL back-to-back clr cycle: got %0d required %0d", clr_at, d1 + 2); end
  endtask

  task automatic test_random();
    logic [PL-1:0] tot;
    for (int j = 0; j < 12; j++) begin
      tot = ($urandom_range(2) == 0) ? '0 : PL'($urandom_range(15, 1));
      run_job($sformatf("rand%0d", j), 2'($urandom), 1'($urandom), FL'($urandom_range(6)),
              tot, int'($urandom_range(18)), int'($urandom_range(3)), int'($urandom_range(3)),
              int'($urandom_range(100)), 1'($urandom), 1'($urandom));
    end
    bus.start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1000000");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_filter_job();
    test_psum_mode();
    test_full_done();
    test_abort();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
